// File: rtl/byte_stream_reader.sv
// Circular byte buffer presenting stored bytes in order on a show-ahead valid/ready stream.
// Optional sticky overflow flag enabled by defining BUF_STATUS_EN.
module byte_stream_reader #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 8,
    parameter int AW    = 4,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             err_ovf
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic             wr_fire;
    logic             rd_fire;

    assign full     = (count_reg == DEPTH_C);
    assign rd_valid = (count_reg != '0);
    assign count    = count_reg;
    assign rd_data  = mem_reg[rd_ptr_reg];

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_valid && rd_ready;

    // Pointers wrap at DEPTH-1, not at a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_fire) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + AW'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage entries; flush leaves contents intact, only reset clears them.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (!flush && wr_fire && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

`ifdef BUF_STATUS_EN
    logic err_ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_reg <= 1'b0;
        end else if (flush) begin
            err_ovf_reg <= 1'b0;
        end else if (wr_en && full) begin
            err_ovf_reg <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_reg;
`else
    assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_byte_stream_reader.sv
// Directed self-checking bench for byte_stream_reader.
module tb_byte_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       err_ovf;

    int checks = 0;
    int errors = 0;

`ifdef BUF_STATUS_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    byte_stream_reader #(.DEPTH(10), .WIDTH(8), .AW(4), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d; rd_ready = 1'b0;
        step();
        wr_en = 1'b0;
        $display("write %h -> count=%0d rd_data=%h", d, count, rd_data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #12;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rd_data); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", err_ovf); end
        rst_n = 1'b1;
        step();
        $display("reset released: count=%0d rd_valid=%b", count, rd_valid);
    endtask

    task automatic test_basic();
        logic [7:0] exp_bytes [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) write_byte(exp_bytes[i]);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL basic_head: got %h expected 11", rd_data); end
        step();
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL basic_stable: got %h expected 11", rd_data); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_data !== exp_bytes[i]) begin errors++; $display("FAIL basic_pop%0d: got %h expected %h", i, rd_data, exp_bytes[i]); end
            $display("pop %h", rd_data);
            step();
        end
        rd_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_empty_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %b expected 0", rd_valid); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 10; i++) write_byte(8'(i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL ovf_count10: got %0d expected 10", count); end
        write_byte(8'hAA);
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL ovf_dropped_count: got %0d expected 10", count); end
        checks++; if (err_ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_flag: got %b expected %b", err_ovf, OVF_EXP); end
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, rd_data, 8'(i)); end
            $display("pop %h", rd_data);
            step();
        end
        rd_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", count); end
        checks++; if (err_ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", err_ovf, OVF_EXP); end
    endtask

    task automatic test_wrap();
        write_byte(8'h40);
        for (int i = 0; i < 25; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h41 + i); rd_ready = 1'b1;
            step();
            $display("wrap %0d: wrote %h rd_data=%h count=%0d", i, wr_data, rd_data, count);
            checks++; if (rd_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, rd_data, 8'(8'h41 + i)); end
            checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 1", i, count); end
        end
        wr_en = 1'b0;
        step();
        rd_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_end: got %0d expected 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 10; i++) write_byte(8'(8'h80 + i));
        wr_en = 1'b1; wr_data = 8'hBB; rd_ready = 1'b1;
        step();
        wr_en = 1'b0;
        $display("full write+pop: count=%0d full=%b rd_data=%h", count, full, rd_data);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL fullpop_count: got %0d expected 9", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b expected 0", full); end
        for (int i = 1; i < 10; i++) begin
            checks++; if (rd_data !== 8'(8'h80 + i)) begin errors++; $display("FAIL fullpop_drain%0d: got %h expected %h", i, rd_data, 8'(8'h80 + i)); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", rd_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", count); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hCC;
        step();
        flush = 1'b0; wr_en = 1'b0;
        $display("flush: count=%0d rd_valid=%b err_ovf=%b", count, rd_valid, err_ovf);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", rd_valid); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", err_ovf); end
        write_byte(8'hDD);
        checks++; if (rd_data !== 8'hDD) begin errors++; $display("FAIL flush_next: got %h expected DD", rd_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL flush_next_count: got %0d expected 1", count); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) write_byte(8'(8'h01 + i));
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL rstmid_pre: got %0d expected 4", count); end
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: count=%0d rd_valid=%b rd_data=%h", count, rd_valid, rd_data);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rd_data); end
        checks++; if (full !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got full=%b ovf=%b expected 0 0", full, err_ovf); end
        step();
        rst_n = 1'b1;
        write_byte(8'h5A);
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rstmid_after_data: got %h expected 5A", rd_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL rstmid_after_count: got %0d expected 1", count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_full_pop();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
